byte_seq_source: RTL and testbench



---
 rtl/byte_seq_source.sv | 131 +++++++++++++
 tb/tb_byte_seq_source.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/byte_seq_source.sv
// Byte-burst source for the max-finder: buffers bytes, sends them as a framed burst,
// then waits for done_in and checks the receiver's max against a locally tracked max.
module byte_seq_source #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       send,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       start,
    output logic [7:0]                 data_out,
    input  logic                       done_in,
    input  logic [7:0]                 max_in,
    output logic [7:0]                 exp_max,
    output logic                       result_valid,
    output logic                       result_ok,
    output logic                       timeout_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_SEND   = 4'b0010;
    localparam logic [3:0] S_WAIT   = 4'b0100;
    localparam logic [3:0] S_REPORT = 4'b1000;

    logic [3:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] len;
    logic [CW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic          wr_ok;
    logic          go;

    assign wr_ok = (state == S_IDLE) && wr_en && !full;
    // A write accepted in the same cycle as send makes an empty buffer sendable.
    assign go    = (state == S_IDLE) && send && ((count != '0) || wr_ok);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            exp_max      <= 8'd0;
            len          <= '0;
            idx          <= '0;
            tcnt         <= '0;
            busy         <= 1'b0;
            start        <= 1'b0;
            data_out     <= 8'd0;
            result_valid <= 1'b0;
            result_ok    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                        full   <= (count == CW'(DEPTH-1));
                        if (wr_data > exp_max)
                            exp_max <= wr_data;
                    end
                    if (go) begin
                        state    <= S_SEND;
                        busy     <= 1'b1;
                        start    <= 1'b1;
                        // Entry 0 is still being written when the buffer was empty.
                        data_out <= (count == '0) ? wr_data : mem[0];
                        len      <= count + CW'(wr_ok);
                        idx      <= CW'(1);
                    end
                end
                S_SEND: begin
                    if (idx == len) begin
                        start    <= 1'b0;
                        data_out <= 8'd0;
                        tcnt     <= '0;
                        state    <= S_WAIT;
                    end else begin
                        data_out <= mem[idx[AW-1:0]];
                        idx      <= idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (done_in) begin
                        state        <= S_REPORT;
                        result_valid <= 1'b1;
                        result_ok    <= (max_in == exp_max);
                        timeout_err  <= 1'b0;
                    end else if (tcnt == TW'(TIMEOUT-1)) begin
                        state        <= S_REPORT;
                        result_valid <= 1'b1;
                        result_ok    <= 1'b0;
                        timeout_err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    wr_ptr  <= '0;
                    count   <= '0;
                    full    <= 1'b0;
                    exp_max <= 8'd0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    start    <= 1'b0;
                    data_out <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_seq_source.sv
// Randomized bench for byte_seq_source against a queue-based reference model.
module tb_byte_seq_source;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, send, done_in;
    logic [7:0] wr_data, max_in;
    logic       full, busy, start, result_valid, result_ok, timeout_err;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [7:0] data_out, exp_max;

    byte_seq_source #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .send(send),
        .full(full), .count(count), .busy(busy), .start(start), .data_out(data_out),
        .done_in(done_in), .max_in(max_in), .exp_max(exp_max),
        .result_valid(result_valid), .result_ok(result_ok), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] ldq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Load ldq, send, play responder (dly<0: never respond; rmax<0: answer the true max).
    task automatic run(input int dly, input int rmax, input bit same_send);
        logic [7:0] mq[$];
        logic [7:0] mx, rsp;
        int got, exp_at, pulses;
        bit exp_ok, exp_to;
        mq = {};
        mx = 0;
        foreach (ldq[i]) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = ldq[i];
            send    = same_send && (i == ldq.size() - 1);
            if (mq.size() < DEPTH) mq.push_back(ldq[i]);
        end
        foreach (mq[i]) if (mq[i] > mx) mx = mq[i];
        @(negedge clk);
        wr_en = 1'b0;
        if (!same_send) begin
            chk("count_loaded", count, mq.size());
            chk("full_loaded", full, mq.size() == DEPTH);
            chk("exp_max_loaded", exp_max, mx);
            chk("busy_idle", busy, 0);
            send = 1'b1;
            @(negedge clk);
        end
        send = 1'b0;
        got = 0;
        while (start === 1'b1 && got <= DEPTH) begin
            if (got < mq.size()) chk("burst_data", data_out, mq[got]);
            got++;
            @(negedge clk);
        end
        chk("burst_len", got, mq.size());
        chk("data_after_burst", data_out, 0);
        chk("busy_wait", busy, 1);
        rsp    = (rmax < 0) ? mx : 8'(rmax);
        exp_to = !(dly >= 0 && dly < TIMEOUT);
        exp_at = exp_to ? TIMEOUT : dly + 1;
        exp_ok = !exp_to && (rsp == mx);
        pulses = 0;
        for (int c = 0; c <= TIMEOUT + 4; c++) begin
            if (result_valid === 1'b1) pulses++;
            if (c == exp_at) begin
                chk("result_valid_time", result_valid, 1);
                chk("result_ok", result_ok, exp_ok);
                chk("timeout_err", timeout_err, exp_to);
                chk("exp_max_report", exp_max, mx);
            end
            if (c == exp_at + 1) begin
                chk("busy_after", busy, 0);
                chk("count_after", count, 0);
                chk("exp_max_after", exp_max, 0);
                chk("result_ok_hold", result_ok, exp_ok);
            end
            done_in = (dly >= 0 && c == dly);
            max_in  = rsp;
            @(negedge clk);
        end
        done_in = 1'b0;
        chk("rv_pulses", pulses, 1);
    endtask

    initial begin
        reset = 1'b1; wr_en = 0; send = 0; done_in = 0; wr_data = 0; max_in = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_exp_max", exp_max, 0);
        chk("rst_rv", result_valid, 0);
        reset = 1'b0;

        ldq = '{8'd3, 8'd200, 8'd17, 8'd255, 8'd0};
        run(2, 255, 0);
        ldq = '{8'd10, 8'd20};
        run(1, 10, 0);
        ldq = '{8'h7f};
        run(-1, -1, 0);
        ldq = '{8'h40, 8'h41};
        run(TIMEOUT - 1, -1, 0);     // done_in on the last waiting cycle beats the timeout

        ldq = {};
        for (int i = 0; i < DEPTH; i++) ldq.push_back(8'($urandom_range(0, 200)));
        ldq.push_back(8'd255);
        run(3, -1, 0);

        @(negedge clk); send = 1'b1;
        @(negedge clk); send = 1'b0;
        chk("empty_send_start", start, 0);
        chk("empty_send_busy", busy, 0);
        @(negedge clk);
        chk("empty_send_busy2", busy, 0);
        ldq = '{8'h05};
        run(0, -1, 1);

        ldq = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4};
        foreach (ldq[i]) begin
            @(negedge clk); wr_en = 1'b1; wr_data = ldq[i];
        end
        @(negedge clk); wr_en = 1'b0; send = 1'b1;
        @(negedge clk); send = 1'b0;
        chk("mid_start1", start, 1);
        chk("mid_data1", data_out, 9);
        @(negedge clk); @(negedge clk);
        chk("mid_data3", data_out, 7);
        reset = 1'b1;
        #1;
        chk("mid_rst_start", start, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_exp_max", exp_max, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk); reset = 1'b0;
        ldq = '{8'd33, 8'd99, 8'd66};
        run(4, -1, 0);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, DEPTH + 3);
            ldq = {};
            for (int i = 0; i < n; i++) ldq.push_back(8'($urandom));
            run($urandom_range(0, 19) - 1, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 255)),
                $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
